// File: rtl/decoder_pkg.sv
// Shared constants and segment table for the keypad digit decoder.
// Imported by decoder and bcd_to_seg.
package decoder_pkg;

    localparam logic [6:0] BLANK_SEG  = 7'b1111111;
    localparam int         MAX_DIGITS = 4;
    localparam int         MAX_CODE   = 9;

    // Active-low patterns, bit order g..a, indexed by BCD code.
    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000,
        7'b0000000,
        7'b0010000
    };

endpackage

// File: rtl/decoder_bcd_to_seg.sv
// BCD code to active-low seven-segment pattern (g..a), combinational.
// Ports: code (4-bit BCD in), seg (7-bit pattern out; blank for 10-15).
module bcd_to_seg
    import decoder_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = BLANK_SEG;
        if (code <= 4'(MAX_CODE))
            seg = SEG_TABLE[code];
    end

endmodule

// File: rtl/decoder.sv
// Keypad digit decoder: synchronizes load, buffers up to four BCD digits,
// and drives four seven-segment patterns plus the binary value.
// Ports: clk, rst_n (sync, active-low), data, load, enable, clear in;
//        hex0..hex3, value, count, new_digit, err out.
module decoder
    import decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  data,
    input  logic        load,
    input  logic        enable,
    input  logic        clear,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [13:0] value,
    output logic [2:0]  count,
    output logic        new_digit,
    output logic        err
);

    logic        s1, s2, s3;
    logic        load_pulse;
    logic        take;
    logic        accept;
    logic        reject;
    logic [3:0]  d [MAX_DIGITS];
    logic [3:0]  m [MAX_DIGITS];
    logic [6:0]  seg [MAX_DIGITS];
    logic [6:0]  hx [MAX_DIGITS];
    logic [13:0] value_next;

    function automatic logic [13:0] times10(input logic [13:0] x);
        return (x << 3) + (x << 1);
    endfunction

    assign load_pulse = s2 & ~s3;
    assign take       = load_pulse & enable & ~clear;
    assign accept     = take & (data <= 4'(MAX_CODE));
    assign reject     = take & (data > 4'(MAX_CODE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Flops reset high so a load held across reset gives no edge.
            s1        <= 1'b1;
            s2        <= 1'b1;
            s3        <= 1'b1;
            count     <= '0;
            err       <= 1'b0;
            new_digit <= 1'b0;
            value     <= '0;
            for (int i = 0; i < MAX_DIGITS; i++)
                d[i] <= '0;
        end else begin
            s1        <= load;
            s2        <= s1;
            s3        <= s2;
            new_digit <= accept;
            value     <= value_next;
            if (clear) begin
                count <= '0;
                err   <= 1'b0;
                for (int i = 0; i < MAX_DIGITS; i++)
                    d[i] <= '0;
            end else if (accept) begin
                d[3] <= d[2];
                d[2] <= d[1];
                d[1] <= d[0];
                d[0] <= data;
                if (count < 3'(MAX_DIGITS))
                    count <= count + 3'd1;
            end else if (reject) begin
                err <= 1'b1;
            end
        end
    end

    // Positions at or beyond count contribute nothing.
    always_comb begin
        for (int i = 0; i < MAX_DIGITS; i++)
            m[i] = (3'(i) < count) ? d[i] : 4'd0;
    end

    // Horner form keeps everything in shift-add; 9999 fits in 14 bits.
    always_comb begin
        value_next = {10'd0, m[3]};
        value_next = times10(value_next) + {10'd0, m[2]};
        value_next = times10(value_next) + {10'd0, m[1]};
        value_next = times10(value_next) + {10'd0, m[0]};
    end

    for (genvar k = 0; k < MAX_DIGITS; k++) begin : g_seg
        bcd_to_seg u_seg (
            .code (d[k]),
            .seg  (seg[k])
        );
        assign hx[k] = (3'(k) < count) ? seg[k] : BLANK_SEG;
    end

    assign hex0 = hx[0];
    assign hex1 = hx[1];
    assign hex2 = hx[2];
    assign hex3 = hx[3];

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for decoder.
// Drives inputs 1ns after posedge, samples outputs likewise.
module tb_decoder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  data;
    logic        load;
    logic        enable;
    logic        clear;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic [13:0] value;
    logic [2:0]  count;
    logic        new_digit;
    logic        err;

    int checks = 0;
    int errors = 0;
    int nd_cnt = 0;
    int nd_ref;

    decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .load      (load),
        .enable    (enable),
        .clear     (clear),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3),
        .value     (value),
        .count     (count),
        .new_digit (new_digit),
        .err       (err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk)
        if (new_digit === 1'b1)
            nd_cnt++;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] v);
        data = v;
        load = 1'b1;
        cyc(4);
        load = 1'b0;
        cyc(5);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(2);
    endtask

    initial begin
        rst_n  = 1'b0;
        data   = 4'd0;
        load   = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);

        // reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_nd", 32'(new_digit), 32'd0);
        chk("rst_hex0", 32'(hex0), 32'h7f);
        chk("rst_hex3", 32'(hex3), 32'h7f);

        // digits 1,2,3
        enable = 1'b1;
        nd_ref = nd_cnt;
        press(4'd1);
        press(4'd2);
        press(4'd3);
        chk("p123_count", 32'(count), 32'd3);
        chk("p123_value", 32'(value), 32'd123);
        chk("p123_hex0", 32'(hex0), 32'b0110000);
        chk("p123_hex1", 32'(hex1), 32'b0100100);
        chk("p123_hex2", 32'(hex2), 32'b1111001);
        chk("p123_hex3", 32'(hex3), 32'h7f);
        chk("p123_pulses", 32'(nd_cnt - nd_ref), 32'd3);

        // overflow the buffer: 9,8,7,6,5 keeps 8765
        press(4'd9);
        press(4'd8);
        press(4'd7);
        press(4'd6);
        press(4'd5);
        chk("p5_count", 32'(count), 32'd4);
        chk("p5_value", 32'(value), 32'd8765);
        chk("p5_hex3", 32'(hex3), 32'b0000000);
        chk("p5_hex0", 32'(hex0), 32'b0010010);

        // long load: one digit only
        do_clear();
        chk("clr1_count", 32'(count), 32'd0);
        nd_ref = nd_cnt;
        data = 4'd4;
        load = 1'b1;
        cyc(1000);
        load = 1'b0;
        cyc(5);
        chk("long_pulses", 32'(nd_cnt - nd_ref), 32'd1);
        chk("long_value", 32'(value), 32'd4);
        chk("long_count", 32'(count), 32'd1);

        // invalid code
        nd_ref = nd_cnt;
        press(4'd12);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_count", 32'(count), 32'd1);
        chk("bad_value", 32'(value), 32'd4);
        chk("bad_pulses", 32'(nd_cnt - nd_ref), 32'd0);
        do_clear();
        chk("clr2_err", 32'(err), 32'd0);
        chk("clr2_count", 32'(count), 32'd0);
        chk("clr2_value", 32'(value), 32'd0);
        chk("clr2_hex0", 32'(hex0), 32'h7f);
        chk("clr2_hex1", 32'(hex1), 32'h7f);
        chk("clr2_hex2", 32'(hex2), 32'h7f);
        chk("clr2_hex3", 32'(hex3), 32'h7f);

        // enable low ignores load
        press(4'd1);
        enable = 1'b0;
        nd_ref = nd_cnt;
        press(4'd5);
        chk("dis_count", 32'(count), 32'd1);
        chk("dis_value", 32'(value), 32'd1);
        chk("dis_pulses", 32'(nd_cnt - nd_ref), 32'd0);
        chk("dis_hex0", 32'(hex0), 32'b1111001);
        enable = 1'b1;

        // clear coincident with load_pulse drops the digit
        nd_ref = nd_cnt;
        data = 4'd2;
        load = 1'b1;
        cyc(2);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(2);
        load = 1'b0;
        cyc(4);
        chk("coin_count", 32'(count), 32'd0);
        chk("coin_pulses", 32'(nd_cnt - nd_ref), 32'd0);
        chk("coin_value", 32'(value), 32'd0);

        // load held high across reset release
        press(4'd3);
        data = 4'd3;
        load = 1'b1;
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        nd_ref = nd_cnt;
        cyc(10);
        chk("rsth_pulses", 32'(nd_cnt - nd_ref), 32'd0);
        chk("rsth_count", 32'(count), 32'd0);
        load = 1'b0;
        cyc(4);
        data = 4'd7;
        load = 1'b1;
        cyc(3);
        chk("rs7_count_n2", 32'(count), 32'd1);
        chk("rs7_nd_n2", 32'(new_digit), 32'd1);
        chk("rs7_value_n2", 32'(value), 32'd0);
        cyc(1);
        chk("rs7_value_n3", 32'(value), 32'd7);
        chk("rs7_nd_n3", 32'(new_digit), 32'd0);
        load = 1'b0;
        cyc(4);
        chk("rs7_pulses", 32'(nd_cnt - nd_ref), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 SHALL have port: clk  input  1  system clock, 50 MHz; the only clock of the block.
REQ-002 SHALL have port: rst_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port: data  input  4  digit code from the keypad encoder; valid codes are 0-9.
REQ-004 SHALL have port: load  input  1  level strobe from the encoder, asynchronous to clk, high for at least 3 clk periods per key press.
REQ-005 SHALL have port: enable  input  1  entry mode; 1 accepts digits, 0 ignores load.
REQ-006 SHALL have port: clear  input  1  synchronous clear of the digit buffer, level-sensitive.
REQ-007 SHALL have ports: hex0, hex1, hex2, hex3  output  7 each  active-low seven-segment patterns, bit order g..a; hex0 is the newest digit.
REQ-008 SHALL have port: value  output  14  binary value of the buffered BCD number, 0-9999.
REQ-009 SHALL have port: count  output  3  number of digits held, 0-4.
REQ-010 SHALL have port: new_digit  output  1  one-cycle pulse when a digit is accepted.
REQ-011 SHALL have port: err  output  1  sticky flag set when an invalid code (10-15) is received.

Function
REQ-012 SHALL pass load through a 2-flop synchronizer (s1, s2) plus a history flop (s3); define load_pulse = s2 & ~s3.
REQ-013 SHALL assert load_pulse for exactly 1 cycle per rising edge of load, regardless of how long load stays high.
REQ-014 SHALL sample data on the cycle load_pulse is high.
  - data is stable while load is high; no data synchronizer is used.
REQ-015 SHALL, when load_pulse=1, enable=1, clear=0 and data<=9, shift the buffer: d3<=d2, d2<=d1, d1<=d0, d0<=data.
REQ-016 SHALL update count to min(count+1, 4) on an accepted digit.
  - At count=4 the oldest digit (d3) is discarded and count stays 4.
REQ-017 SHALL, when load_pulse=1, enable=1, clear=0 and data>9, leave the buffer and count unchanged, set err=1 and not pulse new_digit.
REQ-018 SHALL ignore load_pulse entirely when enable=0: no buffer, count, err or new_digit change.
REQ-019 SHALL, when clear=1, set d0..d3=0, count=0 and err=0 on the next edge.
  - clear has priority over a simultaneous load_pulse; that digit is dropped.
REQ-020 SHALL timing: load first sampled high at edge N -> buffer, count and err update at edge N+2; new_digit high in cycle N+2..N+3; value valid from edge N+3 (registered).
REQ-021 SHALL compute value = d3*1000 + d2*100 + d1*10 + d0 over positions < count; empty positions contribute 0.
  - Computed with shift-add in 14 bits; no overflow is possible.
REQ-022 SHALL drive hexK with the BCD-to-segment pattern of dK when K < count, else 7'b1111111 (blank).
  - Outputs are combinational from registers; no extra latency.
REQ-023 SHALL use segment patterns 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Reset
REQ-024 SHALL, on rst_n=0 at a clk edge, set d0..d3=0, count=0, err=0, new_digit=0 and value=0.
  - All hex outputs are blank after reset.
REQ-025 SHALL reset s1, s2 and s3 to 1, so a load held high across reset release produces no load_pulse.
REQ-026 SHALL abort any in-flight pulse on reset mid-operation; no digit is accepted in the reset cycle or from a load edge that preceded it.

Structure
REQ-027 SHALL place the following in shared package decoder_pkg:
  - constants BLANK_SEG = 7'b1111111, MAX_DIGITS = 4, MAX_CODE = 9;
  - the segment pattern table.
REQ-028 SHALL instantiate combinational sub-module bcd_to_seg (4-bit in, 7-bit out) four times, once per digit.
  - Synchronizer, buffer, count and value logic stay in decoder.

Verification
REQ-029 SHALL cover: reset, enable=1, load pulses with data 1, 2, 3 -> count=3, value=123, hex0=0110000 (3), hex3 blank, three new_digit pulses.
REQ-030 SHALL cover: five digits 9, 8, 7, 6, 5 -> count=4, value=8765, d3 shows 8.
REQ-031 SHALL cover: load held high for 1000 cycles with data=4 -> exactly one new_digit, value=4.
REQ-032 SHALL cover: data=12 with load -> err=1, count and value unchanged; then clear=1 -> err=0, count=0, all hex blank.
REQ-033 SHALL cover: enable=0 with load pulse data=5 -> no change.
  - Plus clear and load_pulse in the same cycle -> count=0 and the digit is dropped.
REQ-034 SHALL cover: load high during and after reset release -> no new_digit until load falls and rises again.
  - Then data=7 -> value=7 exactly 3 edges after the resample.
